// File: rtl/adc_st_pkg.sv
// Shared constants, state encoding and empty-byte helper for the ADC Avalon-ST packer.
package adc_st_pkg;
   localparam int SAMPLE_W         = 32;
   localparam int LANES            = 16;
   localparam int BEAT_W           = 512;
   localparam int EMPTY_W          = 6;
   localparam int BYTES_PER_SAMPLE = 4;
   localparam int LANE_W           = $clog2(LANES);
   localparam int CNT_W            = LANE_W + 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CAPT = 1'b1
   } state_e;

   // Unused bytes in a final beat that carries lanes_used samples.
   function automatic logic [EMPTY_W-1:0] empty_bytes(input logic [CNT_W-1:0] lanes_used);
      logic [CNT_W-1:0] unused;
      unused = CNT_W'(LANES) - lanes_used;
      return EMPTY_W'(unused) * EMPTY_W'(BYTES_PER_SAMPLE);
   endfunction
endpackage

// File: rtl/adc_st_beat_reg.sv
// One-entry Avalon-ST output register: loads a closed beat and holds it until accepted.
module adc_st_beat_reg
   import adc_st_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [BEAT_W-1:0]  load_data,
   input  logic               load_sop,
   input  logic               load_eop,
   input  logic [EMPTY_W-1:0] load_empty,
   input  logic               src_ready,
   output logic               src_valid,
   output logic [BEAT_W-1:0]  src_data,
   output logic               src_sop,
   output logic               src_eop,
   output logic [EMPTY_W-1:0] src_empty
);
   logic               valid_q, valid_d;
   logic [BEAT_W-1:0]  data_q, data_d;
   logic               sop_q, sop_d;
   logic               eop_q, eop_d;
   logic [EMPTY_W-1:0] empty_q, empty_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      empty_d = empty_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
         sop_d   = load_sop;
         eop_d   = load_eop;
         empty_d = load_empty;
      end else if (valid_q && src_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         empty_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         empty_q <= empty_d;
      end
   end

   assign src_valid = valid_q;
   assign src_data  = data_q;
   assign src_sop   = sop_q;
   assign src_eop   = eop_q;
   assign src_empty = empty_q;
endmodule

// File: rtl/adc_st_packer.sv
// Packs a triggered run of ADC samples into 512-bit Avalon-ST beats; lane 0 sits in the top word.
module adc_st_packer
   import adc_st_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                trig,
   input  logic [LEN_W-1:0]    len,
   input  logic                in_valid,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic [BEAT_W-1:0]   src_data,
   output logic                src_valid,
   input  logic                src_ready,
   output logic                src_sop,
   output logic                src_eop,
   output logic [EMPTY_W-1:0]  src_empty,
   output logic                busy,
   output logic [15:0]         overflow_cnt,
   output logic [15:0]         pkt_cnt
);
   state_e                           state_q, state_d;
   logic [LEN_W-1:0]                 rem_q, rem_d;
   logic [LANE_W-1:0]                lane_idx_q, lane_idx_d;
   logic [LANES-1:0][SAMPLE_W-1:0]   acc_q, acc_d;
   logic                             acc_full_q, acc_full_d;
   logic                             acc_last_q, acc_last_d;
   logic [CNT_W-1:0]                 acc_lanes_q, acc_lanes_d;
   logic                             first_pending_q, first_pending_d;
   logic [15:0]                      ovf_q, ovf_d;
   logic [15:0]                      pkt_q, pkt_d;
   logic                             handoff_s, trig_ok_s, accept_s, drop_s, close_s;
   logic [EMPTY_W-1:0]               load_empty_s;

   // A closed beat may move on when the output register is empty or draining this cycle.
   always_comb begin
      handoff_s    = acc_full_q && (!src_valid || src_ready);
      trig_ok_s    = (state_q == IDLE) && !acc_full_q && trig && (len != '0);
      accept_s     = (state_q == CAPT) && in_valid && (!acc_full_q || handoff_s);
      drop_s       = (state_q == CAPT) && in_valid && acc_full_q && !handoff_s;
      close_s      = accept_s && ((lane_idx_q == LANE_W'(LANES - 1)) || (rem_q == LEN_W'(1)));
      load_empty_s = acc_last_q ? empty_bytes(acc_lanes_q) : EMPTY_W'(0);
   end

   always_comb begin
      state_d         = state_q;
      rem_d           = rem_q;
      lane_idx_d      = lane_idx_q;
      acc_d           = acc_q;
      acc_full_d      = acc_full_q;
      acc_last_d      = acc_last_q;
      acc_lanes_d     = acc_lanes_q;
      first_pending_d = first_pending_q;
      ovf_d           = ovf_q;
      pkt_d           = pkt_q;
      // Handoff is applied first so a sample landing in the same cycle starts a zeroed beat.
      if (handoff_s) begin
         acc_d           = '0;
         acc_full_d      = 1'b0;
         first_pending_d = 1'b0;
      end else begin
         acc_full_d = acc_full_q;
      end
      if (trig_ok_s) begin
         state_d         = CAPT;
         rem_d           = len;
         lane_idx_d      = '0;
         first_pending_d = 1'b1;
      end else begin
         state_d = state_d;
      end
      if (accept_s) begin
         acc_d[LANE_W'(LANES - 1) - lane_idx_q] = in_data;
         rem_d      = rem_q - LEN_W'(1);
         lane_idx_d = lane_idx_q + LANE_W'(1);
         if (close_s) begin
            acc_full_d  = 1'b1;
            acc_last_d  = (rem_q == LEN_W'(1));
            acc_lanes_d = CNT_W'(lane_idx_q) + CNT_W'(1);
            lane_idx_d  = '0;
            state_d     = (rem_q == LEN_W'(1)) ? IDLE : CAPT;
         end else begin
            acc_last_d = acc_last_q;
         end
      end else begin
         rem_d = rem_d;
      end
      if (drop_s && (ovf_q != 16'hFFFF)) begin
         ovf_d = ovf_q + 16'd1;
      end else begin
         ovf_d = ovf_q;
      end
      if (src_valid && src_ready && src_eop) begin
         pkt_d = pkt_q + 16'd1;
      end else begin
         pkt_d = pkt_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         rem_q           <= '0;
         lane_idx_q      <= '0;
         acc_q           <= '0;
         acc_full_q      <= 1'b0;
         acc_last_q      <= 1'b0;
         acc_lanes_q     <= '0;
         first_pending_q <= 1'b0;
         ovf_q           <= 16'd0;
         pkt_q           <= 16'd0;
      end else begin
         state_q         <= state_d;
         rem_q           <= rem_d;
         lane_idx_q      <= lane_idx_d;
         acc_q           <= acc_d;
         acc_full_q      <= acc_full_d;
         acc_last_q      <= acc_last_d;
         acc_lanes_q     <= acc_lanes_d;
         first_pending_q <= first_pending_d;
         ovf_q           <= ovf_d;
         pkt_q           <= pkt_d;
      end
   end

   adc_st_beat_reg u_beat_reg (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (handoff_s),
      .load_data  (acc_q),
      .load_sop   (first_pending_q),
      .load_eop   (acc_last_q),
      .load_empty (load_empty_s),
      .src_ready  (src_ready),
      .src_valid  (src_valid),
      .src_data   (src_data),
      .src_sop    (src_sop),
      .src_eop    (src_eop),
      .src_empty  (src_empty)
   );

   assign busy         = (state_q != IDLE) || src_valid;
   assign overflow_cnt = ovf_q;
   assign pkt_cnt      = pkt_q;
endmodule

// File: tb/tb_adc_st_packer.sv
// Directed and randomized bench for adc_st_packer with a packet-level reference model.
module tb_adc_st_packer;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         trig = 1'b0;
   logic [15:0]  len = 16'd0;
   logic         in_valid = 1'b0;
   logic [31:0]  in_data = 32'd0;
   logic         src_ready = 1'b0;
   logic [511:0] src_data;
   logic         src_valid, src_sop, src_eop, busy;
   logic [5:0]   src_empty;
   logic [15:0]  overflow_cnt, pkt_cnt;

   typedef struct packed {
      logic [511:0] data;
      logic         sop;
      logic         eop;
      logic [5:0]   empty;
   } beat_t;

   beat_t        exp_q[$];
   beat_t        mon_t;
   logic [31:0]  pkt_s[$];
   logic [31:0]  vals[$];
   int           n_assert = 0;
   int           n_fail = 0;
   int           beats_seen = 0;
   int           exp_beats = 0;
   int           exp_pkt = 0;
   logic         prev_stall = 1'b0;
   logic [511:0] prev_data;
   logic         prev_sop, prev_eop;
   logic [5:0]   prev_empty;

   always #5 clk = ~clk;

   adc_st_packer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .trig         (trig),
      .len          (len),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .src_data     (src_data),
      .src_valid    (src_valid),
      .src_ready    (src_ready),
      .src_sop      (src_sop),
      .src_eop      (src_eop),
      .src_empty    (src_empty),
      .busy         (busy),
      .overflow_cnt (overflow_cnt),
      .pkt_cnt      (pkt_cnt)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Reference: split the accepted sample list into 16-sample beats, lane 0 in the top word.
   task automatic model_packet();
      int    n, cnt;
      beat_t t;
      n = pkt_s.size();
      for (int b = 0; b < n; b += 16) begin
         cnt    = (n - b < 16) ? (n - b) : 16;
         t.data = '0;
         for (int j = 0; j < cnt; j++) t.data[511 - 32*j -: 32] = pkt_s[b + j];
         t.sop   = (b == 0);
         t.eop   = (b + 16 >= n);
         t.empty = t.eop ? 6'((16 - cnt) * 4) : 6'd0;
         exp_q.push_back(t);
         exp_beats++;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic trigger(input int l);
      trig = 1'b1;
      len  = 16'(l);
      cyc();
      trig = 1'b0;
   endtask

   task automatic drive(input logic [31:0] v);
      in_valid = 1'b1;
      in_data  = v;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic wait_beats();
      int k;
      k = 0;
      while (beats_seen < exp_beats && k < 400) begin
         cyc();
         k++;
      end
      chk("beat_count", 512'(beats_seen), 512'(exp_beats));
   endtask

   task automatic check_pkt();
      exp_pkt++;
      chk("pkt_cnt", 512'(pkt_cnt), 512'(exp_pkt));
   endtask

   // Beat monitor: scoreboard on accept, Avalon-ST hold check while stalled.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_data", src_data, prev_data);
            chk("hold_ctl", {src_valid, src_sop, src_eop, src_empty}, {1'b1, prev_sop, prev_eop, prev_empty});
         end
         if (src_valid && src_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 512'(exp_q.size()), 512'd1);
            end else begin
               mon_t = exp_q.pop_front();
               chk("beat_data", src_data, mon_t.data);
               chk("beat_sop", 512'(src_sop), 512'(mon_t.sop));
               chk("beat_eop", 512'(src_eop), 512'(mon_t.eop));
               chk("beat_empty", 512'(src_empty), 512'(mon_t.empty));
            end
            beats_seen++;
         end
         prev_stall = src_valid && !src_ready;
         prev_data  = src_data;
         prev_sop   = src_sop;
         prev_eop   = src_eop;
         prev_empty = src_empty;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int l;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 512'(src_valid), 512'd0);
      chk("rst_busy", 512'(busy), 512'd0);
      chk("rst_cnts", 512'({overflow_cnt, pkt_cnt}), 512'd0);
      reset_n = 1'b1;
      cyc();

      // len=16, samples 0..15, latency check
      src_ready = 1'b1;
      pkt_s = {};
      for (int i = 0; i < 16; i++) pkt_s.push_back(32'(i));
      model_packet();
      trigger(16);
      for (int i = 0; i < 16; i++) drive(32'(i));
      @(negedge clk);
      chk("lat_early", 512'(src_valid), 512'd0);
      @(negedge clk);
      chk("lat_beat", 512'(src_valid), 512'd1);
      wait_beats();
      check_pkt();

      // len=1
      pkt_s = {32'hA5A5A5A5};
      model_packet();
      trigger(1);
      drive(32'hA5A5A5A5);
      wait_beats();
      check_pkt();

      // len=40 random samples
      pkt_s = {};
      for (int i = 0; i < 40; i++) pkt_s.push_back($urandom);
      model_packet();
      trigger(40);
      for (int i = 0; i < 40; i++) drive(pkt_s[i]);
      wait_beats();
      check_pkt();

      // len=48 with sink stalled: 32 samples buffer, the next 8 are dropped
      vals = {};
      for (int i = 0; i < 56; i++) vals.push_back($urandom);
      pkt_s = {};
      for (int i = 0; i < 32; i++) pkt_s.push_back(vals[i]);
      for (int i = 40; i < 56; i++) pkt_s.push_back(vals[i]);
      model_packet();
      src_ready = 1'b0;
      trigger(48);
      for (int i = 0; i < 40; i++) drive(vals[i]);
      chk("stall_ovf", 512'(overflow_cnt), 512'd8);
      chk("stall_valid", 512'({src_valid, busy}), 512'b11);
      src_ready = 1'b1;
      repeat (4) cyc();
      for (int i = 40; i < 56; i++) drive(vals[i]);
      wait_beats();
      check_pkt();
      chk("ovf_after", 512'(overflow_cnt), 512'd8);

      // Ignored triggers and same-cycle sample
      trigger(0);
      cyc();
      chk("len0_busy", 512'(busy), 512'd0);
      drive(32'hDEADBEEF);
      chk("idle_no_ovf", 512'(overflow_cnt), 512'd8);
      pkt_s = {};
      for (int i = 0; i < 4; i++) pkt_s.push_back($urandom);
      model_packet();
      trig = 1'b1;
      len = 16'd4;
      in_valid = 1'b1;
      in_data = 32'hBAD0BAD0;
      cyc();
      trig = 1'b0;
      in_valid = 1'b0;
      drive(pkt_s[0]);
      trig = 1'b1;
      len = 16'd16;
      drive(pkt_s[1]);
      trig = 1'b0;
      drive(pkt_s[2]);
      drive(pkt_s[3]);
      wait_beats();
      check_pkt();
      repeat (2) cyc();
      chk("ign_trig_idle", 512'(busy), 512'd0);

      // Random lengths with random gaps, sink always ready
      for (int p = 0; p < 3; p++) begin
         l = int'($urandom_range(1, 50));
         pkt_s = {};
         for (int i = 0; i < l; i++) pkt_s.push_back($urandom);
         model_packet();
         trigger(l);
         for (int i = 0; i < l; i++) begin
            if ($urandom_range(0, 3) == 0) cyc();
            drive(pkt_s[i]);
         end
         wait_beats();
         check_pkt();
      end
      chk("rand_ovf", 512'(overflow_cnt), 512'd8);

      // Asynchronous reset mid-packet with a beat waiting
      src_ready = 1'b0;
      trigger(32);
      for (int i = 0; i < 20; i++) drive($urandom);
      chk("pre_rst_valid", 512'(src_valid), 512'd1);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 512'(src_valid), 512'd0);
      chk("arst_busy", 512'(busy), 512'd0);
      chk("arst_cnts", 512'({overflow_cnt, pkt_cnt}), 512'd0);
      exp_pkt = 0;
      cyc();
      reset_n = 1'b1;
      src_ready = 1'b1;
      cyc();
      pkt_s = {32'h11112222, 32'h33334444};
      model_packet();
      trigger(2);
      drive(pkt_s[0]);
      drive(pkt_s[1]);
      wait_beats();
      check_pkt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/adc_st_packer.md
Name: adc_st_packer

Overview:
- Avalon-ST source that packs a triggered run of 32-bit ADC samples into 512-bit packet beats with sop/eop/empty.
- Drives the adc_fifo_0_st_sink conduit of soc_system (data 512, valid/ready, startofpacket, endofpacket, empty 6).
- Sits in the fabric ADC clock domain between the ADC front end and the HPS-visible ADC FIFO.
- One packet per trigger; packet length is set at run time in samples.

Parameters:
- SAMPLE_W, 32, bits per sample (one symbol = 4 bytes).
- LANES, 16, samples per beat; SAMPLE_W*LANES must equal 512.
- LEN_W, 16, width of the packet-length input, in samples.
- EMPTY_W, 6, width of src_empty (byte count, max 60).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- trig  in  1  start-of-acquisition pulse.
- len  in  LEN_W  samples per packet; latched on an accepted trig.
- in_valid  in  1  sample strobe; there is no backpressure to the ADC.
- in_data  in  SAMPLE_W  ADC sample.
- src_data  out  512  beat data; lane 0 (first sample) is in [511:480].
- src_valid  out  1  beat valid.
- src_ready  in  1  sink ready (ready latency 0).
- src_sop  out  1  first beat of packet.
- src_eop  out  1  last beat of packet.
- src_empty  out  EMPTY_W  unused bytes in the eop beat; 0 on all other beats.
- busy  out  1  high when state != IDLE or src_valid.
- overflow_cnt  out  16  samples dropped; saturates at 0xFFFF.
- pkt_cnt  out  16  packets whose eop beat was accepted; wraps.

Behaviour:
- Reset: all outputs and counters go to 0 immediately, asynchronously. The state machine goes to IDLE, and any partial beat or packet is discarded. src_valid falls without waiting for src_ready.
- States: IDLE and CAPT.
- IDLE -> CAPT: on trig with len != 0. len is latched into rem, lane_idx = 0, and first_pending = 1.
- trig with len == 0 is ignored.
- trig while in CAPT is ignored.
- An in_valid in the same cycle as the accepted trig is not captured. Capture starts the next cycle.
- CAPT: each accepted sample is written to lane lane_idx of the accumulator, lane_idx increments, and rem decrements.
- A beat closes when lane_idx reaches LANES-1 or rem == 1 (last sample).
- On the final sample the machine returns to IDLE in the same edge.
- Unused lanes of a short final beat are zero.
- Beat handoff: a closed beat moves to the output register when the output register is empty or is being accepted this cycle (src_valid & src_ready).
- Handoff sets src_sop = first_pending and clears first_pending. It also sets src_eop = last, and src_empty = (LANES - lanes_used) * 4 when eop, else 0.
- Latency: the closing sample at edge N gives src_valid high after edge N+1 if the output register is free.
- Back-to-back full beats with src_ready held high stream at 1 beat per 16 samples with no drops.
- Stall: if the accumulator holds a closed beat that cannot hand off, it holds. Any in_valid arriving then is dropped: overflow_cnt increments, and rem and lane_idx are unchanged (the packet still delivers len samples).
- A new trig is accepted only when the state is IDLE and the accumulator is free. The output register may still hold the previous eop beat.
- Avalon-ST rules: while src_valid && !src_ready, src_data, src_sop, src_eop and src_empty stay stable. src_valid never drops without acceptance, except on reset.
- pkt_cnt increments on the cycle the eop beat is accepted.
- len == 1 gives one beat with src_sop = src_eop = 1 and src_empty = 60.

Decomposition:
- Package adc_st_pkg holds SAMPLE_W, LANES, BEAT_W = 512, EMPTY_W, BYTES_PER_SAMPLE = 4, and the state enum {IDLE, CAPT}.
- Sub-module adc_st_beat_reg is a one-entry Avalon-ST output register (load, valid/ready, sop/eop/empty/data hold).

Test Plan:
- Reset with trig and len=16, 16 samples 0..15, src_ready=1 -> one beat one cycle after the last sample: [511:480]=0, [31:0]=15, sop=1, eop=1, empty=0, pkt_cnt=1.
- len=1, sample 0xA5A5A5A5 -> one beat: [511:480]=0xA5A5A5A5, remainder zero, sop=eop=1, empty=60.
- len=40, continuous samples, ready=1 -> 3 beats: sop 1/0/0, eop 0/0/1, empty 0/0/32; the third beat holds samples 32..39 in lanes 0..7.
- len=48, ready=0 until 40 samples in, then 1 -> beat1 held stable; samples arriving while the accumulator holds a closed beat are dropped (overflow_cnt == dropped count); the packet still completes with 48 samples.
- trig with len=0; trig during CAPT; in_valid in the same cycle as trig -> ignored, ignored, and sample not captured respectively; pkt_cnt unchanged by the ignored triggers.
- reset_n asserted mid-packet with src_valid=1 -> src_valid, busy and counters 0 asynchronously; a new trig after release produces a fresh sop beat.
